mem_access_seq: RTL
===================

Name: mem_access_seq

Overview:
- Sequencer that sits between the control unit and the 64-bit data memory.
- Loads: reads one doubleword, then sign- or zero-extends it by funct3.
- Stores: performs read-modify-write. Sub-doubleword stores (sb/sh/sw) read the old doubleword, merge the new low bytes into it, then write the result back. Full-width stores write directly.
- It is the consumer of the store-size merge stage: that merge logic is instantiated inside this block, and the merge's old-data operand comes from this block's memory read.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from mem_addr issue to valid mem_rdata; legal range 1..15.
- XLEN, 64, data and address width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  control unit presents a memory request.
- req_ready  out  1  sequencer can accept a request (high only in IDLE).
- req_is_store  in  1  1 = store, 0 = load.
- instruction  in  32  current instruction; funct3 = instruction[14:12].
- addr  in  XLEN  doubleword address.
- store_data  in  XLEN  register value to store (regB path).
- mem_addr  out  XLEN  memory address.
- mem_wr  out  1  memory write strobe, one cycle.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data.
- load_data  out  XLEN  extended load result; valid while done=1.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Handshake: a request is accepted when req_valid && req_ready at a rising edge.
  - On accept, latch is_store, funct3, addr and store_data; the inputs may change afterwards.
  - req_ready = (state == IDLE); it is combinational from state.
- States: IDLE, RD_WAIT, WRITE, DONE.
- IDLE transitions on accept:
  - Load -> RD_WAIT.
  - Store with funct3 in {000, 001, 010} -> RD_WAIT.
  - Any other store funct3 -> WRITE, with the latched store_data as write data (full 64-bit write, no read).
- RD_WAIT:
  - mem_addr = latched addr.
  - A 4-bit counter is loaded with MEM_LAT-1 on entry and decrements each cycle.
  - At count 0, capture mem_rdata into the old-data register.
  - Loads then go to DONE; stores go to WRITE.
- Store merge, computed on capture:
  - funct3 010: wdata = {old[63:32], sd[31:0]}.
  - funct3 001: wdata = {old[63:16], sd[15:0]}.
  - funct3 000: wdata = {old[63:8], sd[7:0]}.
  - Merging always replaces the low bytes; there is no byte-lane offset.
- WRITE: mem_wr = 1 for exactly one cycle, with mem_addr = latched addr and mem_wdata = merged data; next state DONE.
- DONE: done = 1 for one cycle; next state IDLE. A new request can be accepted on the cycle after DONE.
- Load extension (registered at capture, held in load_data until the next capture):
  - 000: sign-extend byte.
  - 001: sign-extend half.
  - 010: sign-extend word.
  - 100: zero-extend byte.
  - 101: zero-extend half.
  - 110: zero-extend word.
  - 011 and 111: raw 64 bits.
- Latency from accept to done:
  - Load: MEM_LAT+1 cycles.
  - Sub-doubleword store: MEM_LAT+2 cycles.
  - sd: 2 cycles.
- Outputs outside the listed states:
  - mem_wr = 0 outside WRITE.
  - mem_addr holds the latched addr (it is 0 after reset).
  - mem_wdata holds its last value.
- Reset: asynchronous, from any state, including mid-RD_WAIT or mid-WRITE.
  - state = IDLE; counter = 0.
  - mem_wr, done, busy = 0; req_ready = 1.
  - load_data, mem_wdata, mem_addr and all latches = 0.
  - A write interrupted by reset is dropped; mem_wr falls immediately, without waiting for a clock.
- req_valid while busy is ignored and is not queued.
- MEM_LAT = 1: RD_WAIT lasts exactly one cycle.

Decomposition:
- Shared package mem_pkg holds:
  - the funct3 constants FUNCT3_SB/SH/SW/SD and FUNCT3_LBU/LHU/LWU;
  - the state enum typedef mem_state_t {IDLE, RD_WAIT, WRITE, DONE}.
- One sub-module is natural: load_extend, a pure combinational funct3-driven sign/zero extender.
- The store merge is instantiated from the existing size-merge block; no new copy is written.

Test Plan:
- Load lb, mem_rdata = 64'h0000_0000_0000_0080, MEM_LAT = 2 -> done at accept+3 with load_data = 64'hFFFF_FFFF_FFFF_FF80; the lbu variant gives 64'h80.
- Store sb at addr 0x40, store_data = 64'hAB, old mem = 64'h1122_3344_5566_7788 -> single mem_wr pulse at 0x40 with wdata 64'h1122_3344_5566_77AB; done at accept+4.
- Store sw, store_data = 64'hDEAD_BEEF_CAFE_F00D, old = 64'h1111_2222_3333_4444 -> wdata 64'h1111_2222_CAFE_F00D.
- Store sd, store_data = 64'h0123_4567_89AB_CDEF -> no read; mem_wr in the cycle after accept with that exact value; done at accept+2.
- Reset asserted during WRITE of an sh -> mem_wr drops immediately, no done pulse; after release, req_ready = 1 and load_data = 0.
- Back-to-back: req_valid held high across two loads -> the second is accepted only on the cycle after the first done; req_valid pulses while busy produce no extra done.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer: funct3 encodings
// for the load/store widths and the sequencer state type.
package mem_pkg;

    // Store widths (instruction[14:12] of S-type instructions)
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;
    localparam logic [2:0] FUNCT3_SD  = 3'b011;

    // Load widths; the signed loads share their encodings with the stores
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Pure combinational load extender: narrows the raw doubleword to the
// access width selected by funct3 and sign- or zero-extends it back.
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] ext_o
);

    // Width/signedness select; 011 and 111 leave the doubleword untouched
    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            FUNCT3_LB:  ext_o = {{(XLEN-8){raw_i[7]}},   raw_i[7:0]};
            FUNCT3_LH:  ext_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
            FUNCT3_LW:  ext_o = {{(XLEN-32){raw_i[31]}}, raw_i[31:0]};
            FUNCT3_LBU: ext_o = {{(XLEN-8){1'b0}},       raw_i[7:0]};
            FUNCT3_LHU: ext_o = {{(XLEN-16){1'b0}},      raw_i[15:0]};
            FUNCT3_LWU: ext_o = {{(XLEN-32){1'b0}},      raw_i[31:0]};
            default:    ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/store_size_merge.sv
// Size-merge stage: overlays the low bytes of the store operand onto the
// previous doubleword. Merging is always into the low lanes; any other
// funct3 passes the full store operand through.
module store_size_merge
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] old_data_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [XLEN-1:0] merged_o
);

    // Pick how many low bytes of the new value replace the old doubleword
    always_comb begin
        merged_o = store_data_i;
        case (funct3_i)
            FUNCT3_SB: merged_o = {old_data_i[XLEN-1:8],  store_data_i[7:0]};
            FUNCT3_SH: merged_o = {old_data_i[XLEN-1:16], store_data_i[15:0]};
            FUNCT3_SW: merged_o = {old_data_i[XLEN-1:32], store_data_i[31:0]};
            default:   merged_o = store_data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Memory access sequencer between the control unit and the 64-bit data
// memory. Loads read one doubleword and extend it; sub-doubleword stores
// read-modify-write; sd writes directly.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and depends on
// state alone; req_valid seen while busy is dropped, never queued. All
// request fields are latched at the transfer edge.
//
// MEM_LAT must lie in 1..15 so the initial count fits the 4-bit counter.
module mem_access_seq
    import mem_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int XLEN    = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] load_data,
    output logic            done,
    output logic            busy
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    mem_state_t      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] sd_q, sd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] ld_q, ld_d;

    logic [XLEN-1:0] merged;
    logic [XLEN-1:0] extended;
    logic [2:0]      req_f3;
    logic            req_sub_store;
    logic            unused_instr;

    assign req_f3        = instruction[14:12];
    assign req_sub_store = (req_f3 == FUNCT3_SB) || (req_f3 == FUNCT3_SH) ||
                           (req_f3 == FUNCT3_SW);
    assign unused_instr  = ^{instruction[31:15], instruction[11:0]};

    // Old-data operand of the merge is the doubleword arriving from memory
    store_size_merge #(.XLEN(XLEN)) u_merge (
        .funct3_i     (f3_q),
        .old_data_i   (mem_rdata),
        .store_data_i (sd_q),
        .merged_o     (merged)
    );

    load_extend #(.XLEN(XLEN)) u_extend (
        .funct3_i (f3_q),
        .raw_i    (mem_rdata),
        .ext_o    (extended)
    );

    // Next-state logic: accept in IDLE, count out the read latency, capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        sd_d       = sd_q;
        wdata_d    = wdata_q;
        ld_d       = ld_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    f3_d       = req_f3;
                    addr_d     = addr;
                    sd_d       = store_data;
                    if (!req_is_store || req_sub_store) begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = WRITE;
                        wdata_d = store_data;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (is_store_q) begin
                        wdata_d = merged;
                        state_d = WRITE;
                    end else begin
                        ld_d    = extended;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything from any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            is_store_q <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= '0;
            sd_q       <= '0;
            wdata_q    <= '0;
            ld_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            sd_q       <= sd_d;
            wdata_q    <= wdata_d;
            ld_q       <= ld_d;
        end
    end

    // Strobes decode straight from state so reset kills a write at once
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_wr    = (state_q == WRITE);
    assign done      = (state_q == DONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign load_data = ld_q;

endmodule
